// File: rtl/mem_sched_pkg.sv
// Shared CPU definitions for the memory scheduler: FSM encodings, fetch length,
// default starvation limit and the latched transfer descriptor.
package mem_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  localparam int unsigned LEN_W          = 3;
  localparam logic [2:0]  FETCH_LEN      = 3'd4;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef struct packed {
    logic [31:0]      addr;
    logic [LEN_W-1:0] len;
    logic             owner_ls;
  } xfer_t;

  // Lengths other than 1 or 2 bytes are serviced as a full word
  function automatic logic [LEN_W-1:0] legal_len(input logic [LEN_W-1:0] len);
    case (len)
      3'd1, 3'd2: return len;
      default:    return FETCH_LEN;
    endcase
  endfunction

endpackage

// File: rtl/mem_sched_bytebuf.sv
// Byte assembly buffer: holds store data or collects read bytes, little-endian.
module mem_sched_bytebuf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        cap,
  input  logic [1:0]  cap_idx,
  input  logic [7:0]  din,
  input  logic [1:0]  out_idx,
  output logic [31:0] word_c,
  output logic [7:0]  byte_c
);

  logic [31:0] data_q;

  // word_c already contains the byte being captured this cycle
  always_comb begin
    word_c = data_q;
    byte_c = '0;
    for (int b = 0; b < 4; b++) begin
      if (cap && cap_idx == 2'(b)) word_c[8*b +: 8] = din;
      if (out_idx == 2'(b))        byte_c = data_q[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data_q <= '0;
    else if (load) data_q <= load_val;
    else if (cap)  data_q <= word_c;
  end

endmodule

// File: rtl/mem_sched.sv
// Byte-wide RAM scheduler arbitrating instruction fetch against load/store,
// with starvation protection for fetch and a global pause input.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_busy,
  output logic        if_done,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  ls_len,
  output logic [31:0] ls_rdata,
  output logic        ls_busy,
  output logic        ls_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam int unsigned      CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [1:0]       state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  xfer_t            xfer_q, xfer_d;
  logic [2:0]       last_k;
  logic             done_phase, done_c;
  logic             if_elig, ls_elig, grant, pick_if, cap;
  logic [31:0]      load_val, word_c;
  logic [7:0]       byte_c;

  // Completion/busy decode and arbitration; the done cycle is never a grant cycle
  always_comb begin
    last_k     = (state_q == ST_RD) ? 3'(xfer_q.len + 3'd1) : xfer_q.len;
    done_phase = (state_q != ST_IDLE) && (k_q == last_k);
    done_c     = done_phase && rdy_in;
    if_done    = done_c && !xfer_q.owner_ls;
    ls_done    = done_c && xfer_q.owner_ls;
    if_busy    = (state_q != ST_IDLE) && !xfer_q.owner_ls && !done_c;
    ls_busy    = (state_q != ST_IDLE) && xfer_q.owner_ls && !done_c;
    if_elig    = if_req && !if_done;
    ls_elig    = ls_req && !ls_done;
    grant      = (state_q == ST_IDLE) && rdy_in && (if_elig || ls_elig);
    pick_if    = if_elig && (!ls_elig || starve_q == STARVE_LIM);
    cap        = (state_q == ST_RD) && rdy_in && (k_q != 3'd0) && (k_q <= xfer_q.len);
  end

  // RAM bus; while paused in RD the byte awaiting capture is re-addressed
  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    case (state_q)
      ST_RD: begin
        if (!rdy_in && k_q != 3'd0 && k_q <= xfer_q.len)
          mem_a = xfer_q.addr + 32'(k_q - 3'd1);
        else if (k_q < xfer_q.len)
          mem_a = xfer_q.addr + 32'(k_q);
      end
      ST_WR: begin
        if (k_q < xfer_q.len) begin
          mem_a    = xfer_q.addr + 32'(k_q);
          mem_dout = byte_c;
          mem_wr   = rdy_in;
        end
      end
      default: ;
    endcase
  end

  // Next state, request latch and starvation counter
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    starve_d = starve_q;
    xfer_d   = xfer_q;
    load_val = '0;
    if (grant) begin
      k_d = '0;
      if (pick_if) begin
        xfer_d   = '{addr: if_addr, len: FETCH_LEN, owner_ls: 1'b0};
        starve_d = '0;
        state_d  = ST_RD;
      end else begin
        xfer_d   = '{addr: ls_addr, len: legal_len(ls_len), owner_ls: 1'b1};
        load_val = ls_we ? ls_wdata : '0;
        state_d  = ls_we ? ST_WR : ST_RD;
        if (if_req && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
      end
    end else if (state_q != ST_IDLE && rdy_in) begin
      if (done_phase) state_d = ST_IDLE;
      else            k_d     = k_q + 3'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      starve_q <= '0;
      xfer_q   <= '0;
      if_rdata <= '0;
      ls_rdata <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      starve_q <= starve_d;
      xfer_q   <= xfer_d;
      if (cap && k_q == xfer_q.len) begin
        if (xfer_q.owner_ls) ls_rdata <= word_c;
        else                 if_rdata <= word_c;
      end
    end
  end

  mem_sched_bytebuf u_bytebuf (
    .clk      (clk_in),
    .rst_n    (rst_in),
    .load     (grant),
    .load_val (load_val),
    .cap      (cap),
    .cap_idx  (2'(k_q - 3'd1)),
    .din      (mem_din),
    .out_idx  (k_q[1:0]),
    .word_c   (word_c),
    .byte_c   (byte_c)
  );

endmodule

// File: tb/tb_mem_sched.sv
// Scoreboard bench for mem_sched: stimulus pushes expected completions, a
// negedge monitor pops and checks them against the done pulses.
module tb_mem_sched;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_req, if_busy, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_busy, ls_done;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [2:0]  ls_len;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  always #5 clk_in = ~clk_in;

  mem_sched #(.STARVE_MAX(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_busy(if_busy), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_len(ls_len), .ls_rdata(ls_rdata), .ls_busy(ls_busy), .ls_done(ls_done),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    int          cyc;
    bit          chk_data;
  } exp_t;

  exp_t if_q[$];
  exp_t ls_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [7:0]  ram [4096];
  logic [31:0] t4_data [4] = '{32'h5A, 32'hA5, 32'h3C, 32'hC3};

  always @(posedge clk_in) cyc <= cyc + 1;

  // Byte RAM with one-cycle read latency
  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  always @(negedge clk_in) begin
    if (if_done) begin
      if (if_q.size() == 0) begin
        total++; bad++;
        $display("FAIL if_done unexpected at cycle %0d", cyc);
      end else begin
        mon_e = if_q.pop_front();
        chk({mon_e.tag, " done cycle"}, 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.chk_data) chk({mon_e.tag, " if_rdata"}, if_rdata, mon_e.data);
      end
    end
    if (ls_done) begin
      if (ls_q.size() == 0) begin
        total++; bad++;
        $display("FAIL ls_done unexpected at cycle %0d", cyc);
      end else begin
        mon_e = ls_q.pop_front();
        chk({mon_e.tag, " done cycle"}, 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.chk_data) chk({mon_e.tag, " ls_rdata"}, ls_rdata, mon_e.data);
      end
    end
    if (if_done || ls_done) begin
      chk("done/busy exclusive", {30'b0, if_done & if_busy, ls_done & ls_busy}, 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_in = 1'b0; rdy_in = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_len = 3'd0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'h200] = 8'h5A; ram[12'h201] = 8'hA5; ram[12'h202] = 8'h3C; ram[12'h203] = 8'hC3;
    ram[12'h300] = 8'h01; ram[12'h301] = 8'h02; ram[12'h302] = 8'h03; ram[12'h303] = 8'h04;
    ram[12'h001] = 8'h77; ram[12'h002] = 8'h66;
    ram[12'h501] = 8'h99;

    // Outputs while held in reset
    tick(3);
    @(negedge clk_in);
    chk("reset mem_a", mem_a, 32'h0);
    chk("reset mem_wr/dout", {23'b0, mem_wr, mem_dout}, 32'h0);
    chk("reset busy/done", {28'b0, if_busy, if_done, ls_busy, ls_done}, 32'h0);
    chk("reset if_rdata", if_rdata, 32'h0);
    chk("reset ls_rdata", ls_rdata, 32'h0);
    tick(1);
    rst_in = 1'b1;
    tick(1);

    // Plain fetch; address changes after grant must be ignored
    if_addr = 32'h100; if_req = 1'b1; c = cyc;
    if_q.push_back('{"fetch 0x100", 32'h44332211, c + 6, 1'b1});
    tick(1); if_addr = 32'hDEAD_0000;
    tick(5); if_req = 1'b0;
    tick(2);

    // Simultaneous requests: load wins, fetch follows the cycle after ls_done
    ls_addr = 32'h200; ls_len = 3'd1; ls_we = 1'b0; ls_req = 1'b1;
    if_addr = 32'h100; if_req = 1'b1; c = cyc;
    ls_q.push_back('{"load 0x200 len1", 32'h5A, c + 3, 1'b1});
    if_q.push_back('{"fetch after load", 32'h44332211, c + 10, 1'b1});
    tick(3); ls_req = 1'b0;
    tick(7); if_req = 1'b0;
    tick(2);

    // Wrapping 2-byte store, then illegal-length load over the wrap
    ls_we = 1'b1; ls_addr = 32'hFFFF_FFFF; ls_len = 3'd2; ls_wdata = 32'h1234_BEEF; ls_req = 1'b1; c = cyc;
    ls_q.push_back('{"store wrap", 32'h0, c + 3, 1'b0});
    tick(1); ls_wdata = '0; ls_addr = '0;
    tick(2); ls_req = 1'b0; ls_we = 1'b0;
    tick(2);
    chk("store byte @FFFFFFFF", 32'(ram[12'hFFF]), 32'hEF);
    chk("store byte @00000000", 32'(ram[12'h000]), 32'hBE);
    chk("store no 3rd byte", 32'(ram[12'h001]), 32'h77);
    ls_addr = 32'hFFFF_FFFF; ls_len = 3'd3; ls_req = 1'b1; c = cyc;
    ls_q.push_back('{"load len3 as 4 wrap", 32'h6677BEEF, c + 6, 1'b1});
    tick(6); ls_req = 1'b0;
    tick(2);

    // Starvation: four back-to-back loads, then fetch is forced in
    ls_addr = 32'h200; ls_len = 3'd1; ls_req = 1'b1;
    if_addr = 32'h100; if_req = 1'b1; c = cyc;
    for (int i = 0; i < 4; i++) ls_q.push_back('{"starve load", t4_data[i], c + 3 + 4*i, 1'b1});
    if_q.push_back('{"starved fetch", 32'h44332211, c + 22, 1'b1});
    for (int i = 0; i < 4; i++) begin
      tick(3);
      if (i < 3) ls_addr = 32'h200 + 32'(i + 1);
      tick(1);
    end
    tick(1); ls_req = 1'b0;
    tick(5); if_req = 1'b0;
    tick(2);

    // Three-cycle pause while byte 2 of a fetch is addressed
    if_addr = 32'h300; if_req = 1'b1; c = cyc;
    if_q.push_back('{"paused fetch", 32'h04030201, c + 9, 1'b1});
    tick(3); rdy_in = 1'b0;
    tick(3); rdy_in = 1'b1;
    tick(3); if_req = 1'b0;
    tick(2);

    // Pause during a store byte, then read the word back
    ls_we = 1'b1; ls_addr = 32'h400; ls_len = 3'd4; ls_wdata = 32'hCAFE_F00D; ls_req = 1'b1; c = cyc;
    ls_q.push_back('{"paused store", 32'h0, c + 7, 1'b0});
    tick(2); rdy_in = 1'b0;
    @(negedge clk_in);
    chk("mem_wr while paused", {31'b0, mem_wr}, 32'h0);
    tick(2); rdy_in = 1'b1;
    @(negedge clk_in);
    chk("mem_wr after pause", {31'b0, mem_wr}, 32'h1);
    chk("mem_a after pause", mem_a, 32'h401);
    tick(3); ls_req = 1'b0; ls_we = 1'b0;
    tick(2);
    ls_addr = 32'h400; ls_len = 3'd4; ls_req = 1'b1; c = cyc;
    ls_q.push_back('{"store readback", 32'hCAFEF00D, c + 6, 1'b1});
    tick(6); ls_req = 1'b0;
    tick(2);

    // Reset in the middle of a store aborts it without a done pulse
    ls_we = 1'b1; ls_addr = 32'h500; ls_len = 3'd4; ls_wdata = 32'h1122_3344; ls_req = 1'b1;
    tick(2);
    rst_in = 1'b0;
    #1;
    chk("mem_wr in reset", {31'b0, mem_wr}, 32'h0);
    chk("ls_busy in reset", {31'b0, ls_busy}, 32'h0);
    ls_req = 1'b0; ls_we = 1'b0;
    tick(2); rst_in = 1'b1;
    tick(1);
    chk("aborted store byte0", 32'(ram[12'h500]), 32'h44);
    ls_addr = 32'h500; ls_len = 3'd2; ls_req = 1'b1; c = cyc;
    ls_q.push_back('{"load after reset", 32'h9944, c + 4, 1'b1});
    tick(4); ls_req = 1'b0;
    tick(3);

    chk("if scoreboard drained", 32'(if_q.size()), 32'h0);
    chk("ls scoreboard drained", 32'(ls_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_sched.md
MEM_SCHED -- requirements
Module: mem_sched

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive load/store grants while fetch is waiting.
REQ-002 Port clk_in  input  1: sole clock, rising edge.
REQ-003 Port rst_in  input  1: reset, asynchronous, active-low.
REQ-004 Port rdy_in  input  1: global ready; low = pause.
REQ-005 Port if_req  input  1: fetch read request, level, held until if_done.
REQ-006 Port if_addr  input  32: fetch byte address (4-byte read).
REQ-007 Port if_rdata  output  32: fetched word, little-endian.
REQ-008 Port if_busy / if_done  output  1 each: fetch in service / one-cycle completion pulse.
REQ-009 Port ls_req, ls_we  input  1 each: load/store request (level), 1 = store.
REQ-010 Port ls_addr, ls_wdata  input  32 each: load/store address, store data (low bytes used).
REQ-011 Port ls_len  input  3: transfer length in bytes, legal 1, 2, 4.
REQ-012 Port ls_rdata  output  32: load data, zero-extended, little-endian.
REQ-013 Port ls_busy / ls_done  output  1 each: load/store in service / one-cycle completion pulse.
REQ-014 Port mem_din  input  8: RAM read byte, valid one cycle after its address.
REQ-015 Port mem_dout  output  8: RAM write byte.
REQ-016 Port mem_a  output  32: RAM byte address.
REQ-017 Port mem_wr  output  1: 1 = write, 0 = read.

Function
REQ-018 The FSM shall have states IDLE, RD, WR; grants occur only in IDLE.
REQ-019 Arbitration: ls wins over if unless the starve counter equals STARVE_MAX, then if wins.
REQ-020 Starve counter: +1 on each ls grant while if_req is high; cleared on each if grant; saturates at STARVE_MAX.
REQ-021 A requester whose done pulse is high that cycle is not eligible for a grant that cycle.
REQ-022 On grant, base address, length (fetch = 4), we and wdata shall be latched; later input changes and req deassertion are ignored until done.
REQ-023 RD: byte i address (base+i, i = 0..n-1) on mem_a in RD cycle i; mem_din captured into byte i in cycle i+1.
REQ-024 Read latency: done high exactly n+2 cycles after the grant cycle (4-byte fetch: grant cycle + 6).
REQ-025 WR: byte i of wdata on mem_dout with mem_a = base+i and mem_wr = 1 in WR cycle i; done at grant cycle + n + 1.
REQ-026 Address increment shall wrap modulo 2^32.
REQ-027 rdata shall be updated only at completion and held until the requester's next completion.
REQ-028 busy high from the cycle after grant through the cycle before done; done and busy never both high.
REQ-029 Idle/read cycles: mem_wr = 0, mem_dout = 0; in IDLE mem_a = 0.
REQ-030 rdy_in low: all state frozen, mem_wr forced 0, done not asserted.
REQ-031 After a pause in RD, the pending byte address shall be re-presented before capture resumes; no byte may be lost or duplicated.
REQ-032 A write byte paused by rdy_in low shall be driven with mem_wr = 1 once rdy_in returns high.
REQ-033 Illegal ls_len (0, 3, 5-7) shall be treated as 4.

Reset
REQ-034 rst_in low shall force IDLE, counter 0, all outputs 0, mid-transfer included; no done is issued for an aborted transfer.
REQ-035 Arbitration shall resume on the first rising edge after rst_in goes high.

Structure
REQ-036 State encodings, the length constant 4 and the default STARVE_MAX shall live in the shared CPU definitions package.
REQ-037 Byte assembly/shift logic shall be one sub-module, mem_sched_bytebuf; arbitration and FSM stay in mem_sched.

Verification
REQ-038 Fetch only, if_addr=0x100, RAM[0x100..0x103]=11 22 33 44 -> if_done at grant+6, if_rdata=0x44332211.
REQ-039 Simultaneous if_req and ls_req (load 0x200, len 1), counter 0 -> load first, fetch granted in the cycle after ls_done.
REQ-040 Store len 2, addr 0xFFFFFFFF, data 0xBEEF -> writes EF to 0xFFFFFFFF, BE to 0x00000000, ls_done at grant+3.
REQ-041 ls_req held high continuously, if_req high, STARVE_MAX=4 -> fetch granted after 4th load completes.
REQ-042 rdy_in low 3 cycles during byte 2 of a 4-byte read -> correct word, done delayed by exactly 3 cycles.
REQ-043 rst_in low mid-write -> mem_wr=0 immediately, no done, next request served normally.
